// File: rtl/day1_pkg.sv
// rtl/day1_pkg.sv - shared widths, FSM state type and helpers for the day-1 feed controller
package day1_pkg;

  localparam int VAL_W = 16;
  localparam int IDX_W = 8;
  localparam int PH_W  = 4;

  // A zero value on the datapath bus closes the current elf group.
  localparam logic [VAL_W-1:0] SEP_VAL = '0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/day1_strobe_timer.sv
// rtl/day1_strobe_timer.sv - shared phase counter for the SETUP/STROBE/HOLD phases
module day1_strobe_timer
  import day1_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [PH_W-1:0] len_i,
  output logic            phase_done_o
);

  logic [PH_W-1:0] cnt_q;

  // Reload with length-1 on phase entry, then count down to zero and rest there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= len_i - PH_W'(1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - PH_W'(1);
    end
  end

  // The phase ends on the cycle the counter reads zero.
  assign phase_done_o = (cnt_q == '0);

endmodule

// File: rtl/day1_feed_ctrl.sv
// rtl/day1_feed_ctrl.sv - day-1 datapath feed sequencer; optional DAY1_FEED_ZERO_COLLAPSE_EN
module day1_feed_ctrl
  import day1_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 1,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             s_valid,
  input  logic [VAL_W-1:0] s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic [VAL_W-1:0] dp_val,
  output logic             dp_next,
  input  logic [VAL_W-1:0] dp_highest_sum,
  input  logic [IDX_W-1:0] dp_highest_index,
  output logic             busy,
  output logic             done,
  output logic [15:0]      val_count,
  output logic [7:0]       grp_count,
  output logic [VAL_W-1:0] res_sum,
  output logic [IDX_W-1:0] res_index
`ifdef DAY1_FEED_ZERO_COLLAPSE_EN
  ,
  output logic [15:0]      zero_drop_count
`endif
);

  localparam logic [PH_W-1:0] SETUP_LEN  = PH_W'(SETUP_CYC);
  localparam logic [PH_W-1:0] STROBE_LEN = PH_W'(STROBE_CYC);
  localparam logic [PH_W-1:0] HOLD_LEN   = PH_W'(HOLD_CYC);

  state_e           state_q;
  logic [VAL_W-1:0] dp_val_q;
  logic             dp_next_q;
  logic             last_q;
  logic             busy_q;
  logic             done_q;
  logic [15:0]      val_cnt_q;
  logic [7:0]       grp_cnt_q;
  logic [VAL_W-1:0] res_sum_q;
  logic [IDX_W-1:0] res_idx_q;

  logic             xfer;
  logic             drop;
  logic             tmr_load;
  logic [PH_W-1:0]  tmr_len;
  logic             phase_done;

`ifdef DAY1_FEED_ZERO_COLLAPSE_EN
  // Set when the most recently strobed value was a separator (or nothing strobed yet).
  logic             prev_zero_q;
  logic [15:0]      drop_cnt_q;

  assign drop            = xfer && (s_data == SEP_VAL) && prev_zero_q;
  assign zero_drop_count = drop_cnt_q;
`else
  assign drop = 1'b0;
`endif

  assign s_ready   = (state_q == ST_ACCEPT);
  assign xfer      = s_ready && s_valid;
  assign dp_val    = dp_val_q;
  assign dp_next   = dp_next_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign val_count = val_cnt_q;
  assign grp_count = grp_cnt_q;
  assign res_sum   = res_sum_q;
  assign res_index = res_idx_q;

  // Reload the phase counter on every entry into SETUP, STROBE or HOLD.
  always_comb begin
    tmr_load = 1'b0;
    tmr_len  = SETUP_LEN;
    case (state_q)
      ST_ACCEPT: begin
        if (xfer && !drop) begin
          tmr_load = 1'b1;
          tmr_len  = SETUP_LEN;
        end
      end
      ST_SETUP: begin
        if (phase_done) begin
          tmr_load = 1'b1;
          tmr_len  = STROBE_LEN;
        end
      end
      ST_STROBE: begin
        if (phase_done) begin
          tmr_load = 1'b1;
          tmr_len  = HOLD_LEN;
        end
      end
      ST_HOLD: begin
        if (phase_done && last_q && (dp_val_q != SEP_VAL)) begin
          tmr_load = 1'b1;
          tmr_len  = SETUP_LEN;
        end
      end
      default: ;
    endcase
  end

  day1_strobe_timer u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (tmr_load),
    .len_i        (tmr_len),
    .phase_done_o (phase_done)
  );

  // Run sequencer: accept a value, present it, strobe it, hold it, flush the last group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      dp_val_q  <= '0;
      dp_next_q <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      val_cnt_q <= '0;
      grp_cnt_q <= '0;
      res_sum_q <= '0;
      res_idx_q <= '0;
`ifdef DAY1_FEED_ZERO_COLLAPSE_EN
      prev_zero_q <= 1'b1;
      drop_cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_ACCEPT;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            val_cnt_q <= '0;
            grp_cnt_q <= '0;
            res_sum_q <= '0;
            res_idx_q <= '0;
`ifdef DAY1_FEED_ZERO_COLLAPSE_EN
            prev_zero_q <= 1'b1;
            drop_cnt_q  <= '0;
`endif
          end
        end
        ST_ACCEPT: begin
          if (xfer) begin
            if (drop) begin
`ifdef DAY1_FEED_ZERO_COLLAPSE_EN
              drop_cnt_q <= sat_inc16(drop_cnt_q);
`endif
              if (s_last) begin
                state_q   <= ST_DONE;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                res_sum_q <= dp_highest_sum;
                res_idx_q <= dp_highest_index;
              end
            end else begin
              dp_val_q <= s_data;
              last_q   <= s_last;
              state_q  <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (phase_done) begin
            state_q   <= ST_STROBE;
            dp_next_q <= 1'b1;
            val_cnt_q <= sat_inc16(val_cnt_q);
            if (dp_val_q == SEP_VAL) begin
              grp_cnt_q <= sat_inc8(grp_cnt_q);
            end
`ifdef DAY1_FEED_ZERO_COLLAPSE_EN
            prev_zero_q <= (dp_val_q == SEP_VAL);
`endif
          end
        end
        ST_STROBE: begin
          if (phase_done) begin
            state_q   <= ST_HOLD;
            dp_next_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (phase_done) begin
            if (!last_q) begin
              state_q <= ST_ACCEPT;
            end else if (dp_val_q != SEP_VAL) begin
              // Close the final group with an inserted separator.
              dp_val_q <= SEP_VAL;
              state_q  <= ST_SETUP;
            end else begin
              state_q   <= ST_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              res_sum_q <= dp_highest_sum;
              res_idx_q <= dp_highest_index;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_day1_feed_ctrl.sv
// tb/tb_day1_feed_ctrl.sv - directed self-checking bench for day1_feed_ctrl
module tb_day1_feed_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [15:0] dp_val;
  logic        dp_next;
  logic [15:0] m_hi = '0;
  logic [7:0]  m_hidx = '0;
  logic        busy, done;
  logic [15:0] val_count;
  logic [7:0]  grp_count;
  logic [15:0] res_sum;
  logic [7:0]  res_index;
  logic [15:0] zdc;

  logic        start_b = 1'b0;
  logic        s_valid_b = 1'b0;
  logic [15:0] s_data_b = '0;
  logic        s_last_b = 1'b0;
  logic        s_ready_b;
  logic [15:0] dp_val_b;
  logic        dp_next_b;
  logic        busy_b, done_b;
  logic [15:0] val_count_b;
  logic [7:0]  grp_count_b;
  logic [15:0] res_sum_b;
  logic [7:0]  res_index_b;
  logic [15:0] zdc_b;

  int checks = 0;
  int errors = 0;

  logic [15:0] strobe_q[$];
  logic [15:0] m_cur = '0;
  logic [7:0]  m_gidx = '0;
  logic        m_nx_prev = 1'b0;

  always #5 clk = ~clk;

  day1_feed_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .dp_val(dp_val), .dp_next(dp_next),
    .dp_highest_sum(m_hi), .dp_highest_index(m_hidx),
    .busy(busy), .done(done), .val_count(val_count), .grp_count(grp_count),
    .res_sum(res_sum), .res_index(res_index)
`ifdef DAY1_FEED_ZERO_COLLAPSE_EN
    , .zero_drop_count(zdc)
`endif
  );

  day1_feed_ctrl #(.SETUP_CYC(3), .STROBE_CYC(2), .HOLD_CYC(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .s_valid(s_valid_b), .s_data(s_data_b), .s_last(s_last_b), .s_ready(s_ready_b),
    .dp_val(dp_val_b), .dp_next(dp_next_b),
    .dp_highest_sum(16'd0), .dp_highest_index(8'd0),
    .busy(busy_b), .done(done_b), .val_count(val_count_b), .grp_count(grp_count_b),
    .res_sum(res_sum_b), .res_index(res_index_b)
`ifdef DAY1_FEED_ZERO_COLLAPSE_EN
    , .zero_drop_count(zdc_b)
`endif
  );

  // Behavioural datapath: sums values, a zero closes a group (1-based index), tracks the max.
  always @(negedge clk) begin
    if (dp_next && !m_nx_prev) begin
      strobe_q.push_back(dp_val);
      if (dp_val == 16'd0) begin
        m_gidx = m_gidx + 8'd1;
        if (m_cur > m_hi) begin
          m_hi   = m_cur;
          m_hidx = m_gidx;
        end
        m_cur = '0;
      end else begin
        m_cur = m_cur + dp_val;
      end
    end
    m_nx_prev = dp_next;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    strobe_q.delete();
    m_cur  = '0;
    m_hi   = '0;
    m_hidx = '0;
    m_gidx = '0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    model_clear();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push(input logic [15:0] v, input logic l);
    int n;
    n = 0;
    s_data  = v;
    s_last  = l;
    s_valid = 1'b1;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", {31'd0, done}, 32'd1);
  endtask

  logic [15:0] stream_v[14] = '{16'd1000, 16'd2000, 16'd3000, 16'd0, 16'd4000, 16'd0, 16'd5000,
                                16'd6000, 16'd0, 16'd7000, 16'd8000, 16'd9000, 16'd0, 16'd10000};

  initial begin
    int prev_rdy, rise_c, n;
    logic [15:0] sent, prev_val;
    logic rdy_prev, nx_prev;

    // Reset with valid asserted: everything quiet.
    s_valid = 1'b1;
    s_data  = 16'h1234;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_dp_val", {16'd0, dp_val}, 32'd0);
    chk("rst_dp_next", {31'd0, dp_next}, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_counts", {8'd0, val_count, grp_count}, 32'd0);
    chk("rst_res", {8'd0, res_sum, res_index}, 32'd0);
    chk("rst_b_ready", {31'd0, s_ready_b}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("nostart_ready", {31'd0, s_ready}, 32'd0);
    chk("nostart_dp_val", {16'd0, dp_val}, 32'd0);
    s_valid = 1'b0;

    // Single value with last: value strobe then flush zero, default timing.
    pulse_start();
    chk("start_busy", {31'd0, busy}, 32'd1);
    push(16'h03E8, 1'b1);
    @(negedge clk);
    chk("t1_setup_next", {31'd0, dp_next}, 32'd0);
    chk("t1_setup_val", {16'd0, dp_val}, 32'h03E8);
    @(negedge clk);
    chk("t1_strobe_next", {31'd0, dp_next}, 32'd1);
    @(negedge clk);
    chk("t1_hold_next", {31'd0, dp_next}, 32'd0);
    wait_done();
    chk("t1_val_count", {16'd0, val_count}, 32'd2);
    chk("t1_grp_count", {24'd0, grp_count}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_nstrobes", strobe_q.size(), 32'd2);
    if (strobe_q.size() == 2) begin
      chk("t1_strobe0", {16'd0, strobe_q[0]}, 32'h03E8);
      chk("t1_strobe1", {16'd0, strobe_q[1]}, 32'h0000);
    end
    chk("t1_res_sum", {16'd0, res_sum}, 32'd1000);
    chk("t1_res_index", {24'd0, res_index}, 32'd1);
    repeat (3) @(negedge clk);
    chk("t1_done_held", {31'd0, done}, 32'd1);

    // Full stream with a start pulse mid-run that must be ignored.
    pulse_start();
    chk("t2_cleared", {8'd0, val_count, grp_count}, 32'd0);
    for (int i = 0; i < 14; i++) begin
      push(stream_v[i], (i == 13));
      if (i == 3) begin
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("midstart_busy", {31'd0, busy}, 32'd1);
        chk("midstart_val", {16'd0, val_count}, 32'd4);
        chk("midstart_grp", {24'd0, grp_count}, 32'd1);
      end
    end
    wait_done();
    chk("t2_val_count", {16'd0, val_count}, 32'd15);
    chk("t2_grp_count", {24'd0, grp_count}, 32'd5);
    chk("t2_nstrobes", strobe_q.size(), 32'd15);
    chk("t2_res_sum", {16'd0, res_sum}, 32'h5DC0);
    chk("t2_res_index", {24'd0, res_index}, 32'd4);

    // Zero carrying last: strobed once, no extra flush.
    pulse_start();
    push(16'd9, 1'b0);
    push(16'd0, 1'b1);
    wait_done();
    chk("t3_val_count", {16'd0, val_count}, 32'd2);
    chk("t3_grp_count", {24'd0, grp_count}, 32'd1);
    chk("t3_res_sum", {16'd0, res_sum}, 32'd9);

    // 3/2/4 timing with valid held high.
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    s_data_b  = 16'h0101;
    s_valid_b = 1'b1;
    prev_rdy = -100;
    rise_c   = 0;
    sent     = '0;
    prev_val = dp_val_b;
    rdy_prev = 1'b0;
    nx_prev  = dp_next_b;
    for (int c = 0; c < 45; c++) begin
      if (rdy_prev) s_data_b = s_data_b + 16'd1;
      if (dp_val_b != prev_val) chk("b_val_change", c - prev_rdy, 32'd1);
      if (dp_next_b && !nx_prev) begin
        chk("b_setup", c - prev_rdy, 32'd4);
        chk("b_strobe_val", {16'd0, dp_val_b}, {16'd0, sent});
        rise_c = c;
      end
      if (!dp_next_b && nx_prev) chk("b_strobe_len", c - rise_c, 32'd2);
      if (s_ready_b) begin
        if (prev_rdy >= 0) chk("b_ready_gap", c - prev_rdy, 32'd10);
        prev_rdy = c;
        sent = s_data_b;
      end
      rdy_prev = s_ready_b;
      nx_prev  = dp_next_b;
      prev_val = dp_val_b;
      @(negedge clk);
    end
    s_valid_b = 1'b0;

    // Asynchronous reset in the middle of a strobe, then a clean run.
    pulse_start();
    push(16'd5, 1'b0);
    n = 0;
    while (!dp_next && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_strobe", {31'd0, dp_next}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_next", {31'd0, dp_next}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_ready", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    push(16'd7, 1'b1);
    wait_done();
    chk("t5_val_count", {16'd0, val_count}, 32'd2);
    chk("t5_grp_count", {24'd0, grp_count}, 32'd1);
    chk("t5_res_sum", {16'd0, res_sum}, 32'd7);
    chk("t5_res_index", {24'd0, res_index}, 32'd1);

`ifdef DAY1_FEED_ZERO_COLLAPSE_EN
    // Leading and repeated zeros are consumed without a strobe.
    pulse_start();
    push(16'd0, 1'b0);
    push(16'd5, 1'b0);
    push(16'd0, 1'b0);
    push(16'd0, 1'b0);
    push(16'd7, 1'b1);
    wait_done();
    chk("zc_drops", {16'd0, zdc}, 32'd2);
    chk("zc_grp_count", {24'd0, grp_count}, 32'd2);
    chk("zc_val_count", {16'd0, val_count}, 32'd4);
    chk("zc_nstrobes", strobe_q.size(), 32'd4);
    if (strobe_q.size() == 4) begin
      chk("zc_s0", {16'd0, strobe_q[0]}, 32'd5);
      chk("zc_s1", {16'd0, strobe_q[1]}, 32'd0);
      chk("zc_s2", {16'd0, strobe_q[2]}, 32'd7);
      chk("zc_s3", {16'd0, strobe_q[3]}, 32'd0);
    end
    chk("zc_res_sum", {16'd0, res_sum}, 32'd7);
    chk("zc_res_index", {24'd0, res_index}, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/day1_feed_ctrl.md
Name: day1_feed_ctrl

Overview:
- Clocked sequencer that feeds the day-1 calorie-summing datapath (16-bit value bus plus `next_val` strobe; a zero value closes an elf group).
- Accepts a valid/ready stream of 16-bit calorie values from an upstream loader.
- Drives the datapath's value bus and strobe with programmable setup/strobe/hold timing.
- Closes the final group automatically, counts values and groups, and captures the datapath's highest-sum/index result when the run completes.

Parameters:
- SETUP_CYC, 1, cycles `dp_val` is stable before `dp_next` rises (1..15).
- STROBE_CYC, 1, cycles `dp_next` is held high (1..15).
- HOLD_CYC, 1, cycles `dp_next` is low with `dp_val` stable after the strobe (1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run; clears counters and results
- s_valid  in  1  upstream value valid
- s_data  in  16  upstream calorie value; 0 = group separator
- s_last  in  1  qualifies final value of the input
- s_ready  out  1  controller accepts `s_data` this cycle
- dp_val  out  16  to datapath `par_input`
- dp_next  out  1  to datapath `next_val`
- dp_highest_sum  in  16  from datapath `highest_val_sum`
- dp_highest_index  in  8  from datapath `highest_val_index`
- busy  out  1  run in progress
- done  out  1  run complete; results valid; held until next start
- val_count  out  16  values strobed, including flush zero
- grp_count  out  8  separators strobed, i.e. closed groups
- res_sum  out  16  captured highest sum
- res_index  out  8  captured highest index

Behaviour:
- Reset, asynchronous: state IDLE; every output is 0, including `s_ready`, `dp_val` and `dp_next`.
- FSM states: IDLE, ACCEPT, SETUP, STROBE, HOLD, DONE.
- IDLE or DONE + start → ACCEPT:
  - clears `val_count`, `grp_count`, `res_*` and `done`;
  - sets `busy`;
  - `dp_val` is kept.
- ACCEPT:
  - `s_ready` = 1, combinational from state only.
  - A transfer occurs when `s_valid` and `s_ready` are both high.
  - On transfer: register `dp_val` <= `s_data`, record `last_flag` <= `s_last`, go to SETUP.
- SETUP: `dp_next` = 0 for SETUP_CYC cycles, then STROBE.
- STROBE:
  - `dp_next` = 1 (registered) for STROBE_CYC cycles.
  - On the first STROBE cycle, `val_count` += 1; `grp_count` += 1 if `dp_val` == 0.
  - Then go to HOLD.
- HOLD: `dp_next` = 0 for HOLD_CYC cycles. Exit:
  - `last_flag` = 0 → ACCEPT.
  - `last_flag` = 1 and `dp_val` != 0 → flush: `dp_val` <= 0, `last_flag` stays 1, go to SETUP. The final group is closed with an inserted zero.
  - `last_flag` = 1 and `dp_val` == 0 → DONE.
- DONE:
  - `res_sum` <= `dp_highest_sum` and `res_index` <= `dp_highest_index`, captured on entry.
  - `busy` = 0, `done` = 1.
- Latency: transfer at edge t; `dp_next` is high on cycles t+SETUP_CYC+1 .. t+SETUP_CYC+STROBE_CYC. Next `s_ready` comes SETUP+STROBE+HOLD+1 cycles after the transfer.
- One phase counter (4 bits) is shared by SETUP, STROBE and HOLD. It reloads on every state entry.
- Counters saturate at all-ones; they do not wrap.
- `start` while `busy` is ignored.
- `start` in DONE starts a new run immediately.
- `s_valid` outside ACCEPT is ignored; no data is consumed.
- `s_data` = 0 with `s_last` = 1: strobed once; no extra flush.
- Reset mid-strobe: `dp_next` drops immediately; the run is aborted.

Optional Feature:
- Macro: DAY1_FEED_ZERO_COLLAPSE_EN.
- Defined:
  - An accepted zero whose preceding strobed value was also zero, or the first value of a run being zero, is consumed but not strobed.
  - `s_ready` is returned the next cycle.
  - A 16-bit output `zero_drop_count` counts such drops.
  - If the dropped zero carries `s_last`, go straight to DONE.
- Undefined: every accepted value is strobed; the `zero_drop_count` port is absent.

Decomposition:
- Package `day1_pkg`:
  - `VAL_W` = 16, `IDX_W` = 8;
  - FSM state enum typedef;
  - `SEP_VAL` = 0.
- One sub-module is natural: `day1_strobe_timer`. It holds the phase counter and emits `phase_done` for SETUP/STROBE/HOLD lengths.

Test Plan:
- Reset with `s_valid` = 1 → all outputs 0 and `s_ready` = 0; after release with no start, no transfer occurs.
- Defaults; start; single value 0x03E8 with `s_last` → two strobes (0x03E8, then flush 0x0000); `val_count` = 2, `grp_count` = 1, `done` = 1. Strobe high exactly 1 cycle, 2 cycles after the transfer edge.
- Stream 1000,2000,3000,0,4000,0,5000,6000,0,7000,8000,9000,0,10000 (last), driving the real datapath → 15 strobes, `grp_count` = 5, `res_sum` = 0x5DC0 (24000), `res_index` = the datapath's index for group 4.
- SETUP_CYC=3, STROBE_CYC=2, HOLD_CYC=4 with `s_valid` held high → `s_ready` pulses every 10 cycles; `dp_val` is stable from 3 cycles before `dp_next` rises until `s_ready`.
- Start pulse mid-run → ignored, counters unchanged; assert `rst_n` low mid-STROBE → `dp_next` = 0 asynchronously; the next start runs cleanly.
- With DAY1_FEED_ZERO_COLLAPSE_EN: stream 0,5,0,0,7 (last) → strobes 5,0,7,0; `zero_drop_count` = 2, `grp_count` = 2.
